// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply/divide producing {hi,lo}; zero latency.
// No backpressure: the result follows the operands in the same cycle.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] sq;
    logic [31:0] sr;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign div_zero = (b == 32'd0);
    assign b_safe   = div_zero ? 32'd1 : b;
    assign a_mag    = a[31] ? (~a + 32'd1) : a;
    assign b_mag    = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    assign q_mag    = a_mag / b_mag;
    assign r_mag    = a_mag % b_mag;
    assign sq       = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    assign sr       = a[31] ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MD_MULT:  {hi, lo} = sprod;
            MD_MULTU: {hi, lo} = uprod;
            MD_DIV: begin
                hi = sr;
                lo = sq;
            end
            MD_DIVU: begin
                hi = a % b_safe;
                lo = a / b_safe;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// E-stage mult/div controller owning HI/LO; results commit MULT_CYCLES/DIV_CYCLES after issue.
// Backpressure: Stall holds a D-stage MD instruction while an operation is pending or issuing.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    input  logic        MDUse,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_zero;

    md_arith u_arith (
        .op       (MDOp),
        .a        (A),
        .b        (B),
        .hi       (res_hi),
        .lo       (res_lo),
        .div_zero (div_zero)
    );

    assign Stall = MDUse && (Busy || (Start && !Cancel));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Busy    <= 1'b0;
            cnt     <= '0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (Busy) begin
            if (cnt == CNT_W'(1)) begin
                Busy <= 1'b0;
                cnt  <= '0;
                HI   <= pend_hi;
                LO   <= pend_lo;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (Start && !Cancel) begin
            case (MDOp)
                MD_MULT, MD_MULTU: begin
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    cnt     <= CNT_W'(MULT_CYCLES);
                    Busy    <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    // Divide by zero recommits the current HI/LO; mthi/mtlo cannot intervene while busy.
                    pend_hi <= div_zero ? HI : res_hi;
                    pend_lo <= div_zero ? LO : res_lo;
                    cnt     <= CNT_W'(DIV_CYCLES);
                    Busy    <= 1'b1;
                end
                MD_MTHI: HI <= A;
                MD_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_start_while_busy: assert property (@(posedge Clk) disable iff (Reset)
        !(Start && !Cancel && Busy));
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed vector table, multi-cycle corner sequences, random ops vs a reference model.
module tb_md_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MDOp = 3'd7;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Cancel = 1'b0;
    logic        MDUse = 1'b0;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;

    md_ctrl dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .MDOp   (MDOp),
        .A      (A),
        .B      (B),
        .Cancel (Cancel),
        .MDUse  (MDUse),
        .Busy   (Busy),
        .Stall  (Stall),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called 1 time unit after an edge with Busy low; returns number of cycles Busy was seen high.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cancel, output int nbusy);
        Start  = 1'b1;
        MDOp   = op;
        A      = a;
        B      = b;
        Cancel = cancel;
        tick();
        Start  = 1'b0;
        Cancel = 1'b0;
        nbusy  = 0;
        while (Busy && nbusy < 40) begin
            nbusy++;
            tick();
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int n);
        longint      sp;
        logic [63:0] up;
        longint      q;
        longint      r;
        n = 0;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
                n  = 5;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
                n  = 5;
            end
            3'd2: begin
                if (b != 0) begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    lo = q[31:0];
                    hi = r[31:0];
                end
                n = 10;
            end
            3'd3: begin
                if (b != 0) begin
                    lo = a / b;
                    hi = a % b;
                end
                n = 10;
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    initial begin
        int          nb;
        int          nst;
        logic [31:0] mhi;
        logic [31:0] mlo;
        int          mn;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3]  = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3,        10};
        tbl[4]  = '{3'd4, 32'h1234,     32'd0,        32'h1234,     32'd3,        0};
        tbl[5]  = '{3'd5, 32'h5678,     32'd0,        32'h1234,     32'h5678,     0};
        tbl[6]  = '{3'd3, 32'hDEAD,     32'd0,        32'h1234,     32'h5678,     10};
        tbl[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        tbl[8]  = '{3'd6, 32'hAAAA,     32'hBBBB,     32'd0,        32'h80000000, 0};
        tbl[9]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        tbl[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
        tbl[11] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10};

        tick();
        tick();
        Reset = 1'b0;
        chk("reset_busy", Busy, 0);
        chk("reset_stall", Stall, 0);
        chk("reset_hi", HI, 0);
        chk("reset_lo", LO, 0);

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, nb);
            chk($sformatf("vec%0d_busy", i), nb, tbl[i].busy);
            chk($sformatf("vec%0d_hi", i), HI, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), LO, tbl[i].lo);
        end

        // Stall held across a whole mult with MDUse asserted.
        MDUse = 1'b1;
        Start = 1'b1;
        MDOp  = 3'd0;
        A     = 32'd3;
        B     = 32'd5;
        #1;
        chk("stall_start_cycle", Stall, 1);
        tick();
        Start = 1'b0;
        #1;
        nst = 0;
        nb  = 0;
        while (Busy && nb < 40) begin
            nb++;
            if (Stall) nst++;
            tick();
        end
        chk("stall_busy_cycles", nst, 5);
        chk("stall_after_fall", Stall, 0);
        chk("stall_mult_lo", LO, 15);

        // Start together with Cancel issues nothing.
        Start  = 1'b1;
        Cancel = 1'b1;
        MDOp   = 3'd0;
        A      = 32'd3;
        B      = 32'd4;
        #1;
        chk("cancel_start_stall", Stall, 0);
        tick();
        Start  = 1'b0;
        Cancel = 1'b0;
        MDUse  = 1'b0;
        chk("cancel_start_busy", Busy, 0);
        tick();
        chk("cancel_start_busy2", Busy, 0);
        chk("cancel_start_hi", HI, 0);
        chk("cancel_start_lo", LO, 15);

        // Cancel on busy cycle 2 does not abort the mult.
        Start = 1'b1;
        MDOp  = 3'd0;
        A     = 32'd3;
        B     = 32'd4;
        tick();
        Start = 1'b0;
        nb    = 1;
        tick();
        Cancel = 1'b1;
        nb++;
        tick();
        Cancel = 1'b0;
        while (Busy && nb < 40) begin
            nb++;
            tick();
        end
        chk("cancel_busy_cycles", nb, 5);
        chk("cancel_busy_hi", HI, 0);
        chk("cancel_busy_lo", LO, 12);

        // Reset on busy cycle 3 of a div kills the pending commit.
        issue(3'd4, 32'hCAFE, 32'd0, 1'b0, nb);
        Start = 1'b1;
        MDOp  = 3'd2;
        A     = 32'd100;
        B     = 32'd7;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("rst_mid_busy_before", Busy, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_hi", HI, 0);
        chk("rst_mid_lo", LO, 0);
        repeat (12) tick();
        chk("rst_mid_late_busy", Busy, 0);
        chk("rst_mid_late_hi", HI, 0);
        chk("rst_mid_late_lo", LO, 0);

        // Random operations against the reference model.
        mhi = 32'd0;
        mlo = 32'd0;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            rc = ($urandom_range(0, 7) == 0);
            if (rc) mn = 0;
            else model(rop, ra, rb, mhi, mlo, mn);
            issue(rop, ra, rb, rc, nb);
            chk($sformatf("rnd%0d_busy", i), nb, mn);
            chk($sformatf("rnd%0d_hi", i), HI, mhi);
            chk($sformatf("rnd%0d_lo", i), LO, mlo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide controller for the E stage of the 5-stage pipeline. It owns the HI/LO registers.
- It sequences a fixed-latency multiply/divide operation, and it raises a stall request to the hazard unit while a result is pending.
- It accepts cancellation of the issuing instruction when an interrupt, exception or eret flushes E in the same cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  E-stage instruction is an MD op, qualified by the E-stage valid bit
- MDOp  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 are no-op
- A  in  32  forwarded rs operand (ForwardE1)
- B  in  32  forwarded rt operand (ForwardE2)
- Cancel  in  1  IntReq or eret this cycle; the E-stage instruction is being flushed
- MDUse  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- Busy  out  1  multi-cycle operation in progress
- Stall  out  1  stall request to the hazard unit
- HI  out  32  HI register, read by mfhi
- LO  out  32  LO register, read by mflo

Behaviour:
- Reset: Busy=0, counter=0, HI=0, LO=0, pending registers=0. Reset overrides every other input, including mid-operation.
- Stall = MDUse && (Busy || (Start && !Cancel)). This is combinational and adds no state.
- Issue, at an edge with Start && !Cancel && !Busy:
  - mult/multu/div/divu: compute the 64-bit result and latch it in PendHI/PendLO. Load counter with MULT_CYCLES or DIV_CYCLES. Set Busy=1.
  - mthi: HI<=A at this edge. mtlo: LO<=A at this edge. Busy stays 0.
  - MDOp 6-7: no effect.
- Arithmetic:
  - mult: signed 32x32 product to {HI,LO}.
  - multu: unsigned 32x32 product to {HI,LO}.
  - div: LO=signed quotient, HI=signed remainder. Truncate toward zero; the remainder takes the sign of the dividend.
  - divu: unsigned quotient to LO, unsigned remainder to HI.
  - Divide by zero (B==0): the full busy period still elapses, HI/LO stay unchanged, and no exception is raised.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Counting:
  - While Busy, the counter decrements at each edge.
  - At the edge where counter==1: HI<=PendHI, LO<=PendLO, counter<=0, Busy<=0.
  - Busy is therefore high for exactly N cycles after the issue edge. The new HI/LO are visible in the cycle Busy falls.
- Cancel:
  - Cancel with Start at the same edge: the operation is not issued and no state changes.
  - Cancel during Busy does not abort. The issuing instruction has already left E, so it must complete.
- Start while Busy: ignored. The hazard unit guarantees this never happens; the block asserts it in simulation only.
- No cycle ever has two writes to HI or LO, because issue and commit are mutually exclusive while Busy.

Decomposition:
- Shared package (md_pkg):
  - MDOp encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default latency constants.
- One sub-module, md_arith: combinational, producing a 64-bit {hi,lo} from MDOp, A and B, plus a div_zero flag.
- md_ctrl holds the counter, Busy, the pending registers, HI/LO and Stall.

Test Plan:
- mult A=0xFFFFFFFF B=2:
  - Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7) B=2: Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 gives LO=3, HI=1.
- divu with B=0 after mthi 0x1234/mtlo 0x5678: Busy high 10 cycles, HI=0x1234 and LO=0x5678 unchanged.
- MDUse=1 held during a mult: Stall=1 in the Start cycle and for all 5 Busy cycles, and 0 in the cycle after Busy falls.
- Start=1 with Cancel=1 for mult 3*4: Busy stays 0 and HI/LO are unchanged. Cancel asserted on Busy cycle 2 of a mult: the result still commits on schedule.
- Reset asserted on Busy cycle 3 of a div: on the next cycle Busy=0, HI=0, LO=0, and no late commit occurs.
